// File: rtl/game_flow_controller.sv
// Game sequencer for the falling-square game: start sync, frame tick, countdown,
// scoring and game-over detection driving the square coordinate controller.
module game_flow_controller #(
  parameter int TICK_DIV        = 1666667,
  parameter int COUNTDOWN_TICKS = 180,
  parameter int SCORE_DIV       = 6,
  parameter int SCORE_W         = 16,
  parameter int COORD_W         = 10,
  parameter int FLOOR_Y         = 496
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START_BTN,
  input  logic               DROP_FINISH,
  input  logic               COLLISION,
  input  logic [COORD_W-1:0] SQUARE_Y,
  output logic               DROP_START,
  output logic               FREE_MOVE,
  output logic               GAME_OVER,
  output logic               SQUARE_RESET,
  output logic               FRAME_TICK,
  output logic [7:0]         COUNTDOWN,
  output logic [SCORE_W-1:0] SCORE,
  output logic [SCORE_W-1:0] HIGH_SCORE,
  output logic [2:0]         STATE
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (COUNTDOWN_TICKS < 2) ? 1 : $clog2(COUNTDOWN_TICKS + 1);
  localparam int SW = (SCORE_DIV < 2) ? 1 : $clog2(SCORE_DIV);
  localparam logic [31:0] FLOOR_U = FLOOR_Y;

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_DROP = 3'b001,
    S_CD   = 3'b011,
    S_PLAY = 3'b010,
    S_OVER = 3'b110
  } state_t;

  state_t          state;
  logic            sync1, sync2, prev;
  logic            start_edge;
  logic [TW-1:0]   tick_cnt;
  logic [CW-1:0]   cd;
  logic [SW-1:0]   sub;
  logic            over_cond;

  function automatic logic [7:0] sat8(input logic [CW-1:0] v);
    return (32'(v) > 32'd255) ? 8'hFF : 8'(v);
  endfunction

  assign start_edge = sync2 & ~prev;
  assign over_cond  = COLLISION | (32'(SQUARE_Y) >= FLOOR_U);
  assign STATE      = state;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= START_BTN;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // FRAME_TICK is registered one count early so it lines up with tick_cnt == TICK_DIV-1.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_cnt   <= '0;
      FRAME_TICK <= 1'b0;
    end else begin
      tick_cnt   <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
      FRAME_TICK <= (tick_cnt == TW'(TICK_DIV - 2));
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= S_IDLE;
      cd           <= '0;
      sub          <= '0;
      DROP_START   <= 1'b0;
      SQUARE_RESET <= 1'b0;
      FREE_MOVE    <= 1'b0;
      GAME_OVER    <= 1'b0;
      COUNTDOWN    <= 8'd0;
      SCORE        <= '0;
      HIGH_SCORE   <= '0;
    end else begin
      DROP_START   <= 1'b0;
      SQUARE_RESET <= 1'b0;
      case (state)
        S_IDLE: if (start_edge) begin
          state      <= S_DROP;
          DROP_START <= 1'b1;
          SCORE      <= '0;
          sub        <= '0;
        end
        S_DROP: if (DROP_FINISH) begin
          state     <= S_CD;
          cd        <= CW'(COUNTDOWN_TICKS);
          COUNTDOWN <= sat8(CW'(COUNTDOWN_TICKS));
        end
        S_CD: if (FRAME_TICK) begin
          if (cd == '0) begin
            state     <= S_PLAY;
            FREE_MOVE <= 1'b1;
          end else begin
            cd        <= cd - 1'b1;
            COUNTDOWN <= sat8(cd - 1'b1);
          end
        end
        // Game over outranks a coincident scoring tick; high score uses pre-increment score.
        S_PLAY: begin
          if (over_cond) begin
            state     <= S_OVER;
            GAME_OVER <= 1'b1;
            if (SCORE > HIGH_SCORE) HIGH_SCORE <= SCORE;
          end else if (FRAME_TICK) begin
            if (sub == SW'(SCORE_DIV - 1)) begin
              sub <= '0;
              if (SCORE != {SCORE_W{1'b1}}) SCORE <= SCORE + 1'b1;
            end else begin
              sub <= sub + 1'b1;
            end
          end
        end
        S_OVER: if (start_edge) begin
          state        <= S_IDLE;
          SQUARE_RESET <= 1'b1;
          FREE_MOVE    <= 1'b0;
          GAME_OVER    <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer for the falling-square game.
- Drives the square coordinate controller: DROP_START, FREE_MOVE, GAME_OVER and a restart reset.
- Generates the frame tick, runs the pre-play countdown, keeps score and high score, and decides game over from the collision flag and the square's Y position.
- Sits between the start button / obstacle collision logic and the square controller; its outputs also feed the VGA text overlay.

Parameters:
- TICK_DIV, 1666667, CLK cycles per frame tick (60 Hz at 100 MHz); legal range ≥2.
- COUNTDOWN_TICKS, 180, frame ticks between drop finish and FREE_MOVE.
- SCORE_DIV, 6, frame ticks per score increment while playing; legal range ≥1.
- SCORE_W, 16, score width.
- COORD_W, 10, width of the square Y coordinate.
- FLOOR_Y, 496, Y value at or above which the square has hit the floor.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- START_BTN  in  1  debounced start/restart button, asynchronous to CLK.
- DROP_FINISH  in  1  from square controller, high while drop complete.
- COLLISION  in  1  square/obstacle overlap flag, synchronous.
- SQUARE_Y  in  COORD_W  current square Y coordinate.
- DROP_START  out  1  one-cycle pulse starting the drop.
- FREE_MOVE  out  1  level, high in PLAYING and OVER.
- GAME_OVER  out  1  level, high in OVER.
- SQUARE_RESET  out  1  one-cycle pulse resetting the square controller on restart.
- FRAME_TICK  out  1  one-cycle frame tick.
- COUNTDOWN  out  8  remaining countdown ticks, saturated to 255 for display.
- SCORE  out  SCORE_W  current score.
- HIGH_SCORE  out  SCORE_W  best score since reset.
- STATE  out  3  current state encoding.

Behaviour:
- Reset: RESET_N low asynchronously clears everything.
  - All outputs 0; state IDLE; tick counter 0; sync flops 0.
  - Reset mid-game returns to IDLE immediately; HIGH_SCORE is also cleared.
- Start edge detection:
  - START_BTN passes through a 2-flop synchronizer plus a previous-value flop.
  - start_edge = sync2 & ~prev.
  - Total latency from the first edge sampling START_BTN high to the registered effect is 2 cycles.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1, runs in all states.
  - FRAME_TICK is high for the one cycle in which the counter equals TICK_DIV-1, then the counter wraps to 0.
- States (encoding): IDLE=000, DROPPING=001, COUNTDOWN=011, PLAYING=010, OVER=110.
- IDLE:
  - On start_edge: go to DROPPING; DROP_START=1 for exactly one cycle; SCORE cleared.
- DROPPING:
  - When DROP_FINISH=1: go to COUNTDOWN and load the countdown with COUNTDOWN_TICKS.
  - start_edge is ignored.
- COUNTDOWN:
  - Decrement by 1 on each FRAME_TICK.
  - A FRAME_TICK while the count is 0 moves to PLAYING and sets FREE_MOVE=1.
  - The countdown register stays at 0 in later states.
- PLAYING:
  - A tick sub-counter (0..SCORE_DIV-1) advances on FRAME_TICK.
  - When the sub-counter wraps, SCORE increments by 1, saturating at all-ones.
  - COLLISION=1 or SQUARE_Y ≥ FLOOR_Y (unsigned compare): go to OVER and set GAME_OVER=1.
  - On that same cycle, HIGH_SCORE ← SCORE if SCORE > HIGH_SCORE.
- OVER:
  - SCORE and HIGH_SCORE are frozen; FREE_MOVE and GAME_OVER stay high.
  - On start_edge: SQUARE_RESET=1 for one cycle; FREE_MOVE and GAME_OVER drop to 0; go to IDLE. SCORE is held until the next start.
- Simultaneous events:
  - Game-over condition plus a scoring tick in the same cycle: game over wins and SCORE does not increment.
  - The HIGH_SCORE compare uses the pre-increment SCORE.
  - DROP_FINISH already high on entry to DROPPING is honoured on the next cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (TICK_DIV=4, COUNTDOWN_TICKS=2, SCORE_DIV=2, FLOOR_Y=496):
- Reset, then pulse START_BTN high for 5 cycles.
  - DROP_START high exactly once, 2 cycles after first sampled high; STATE=001; SCORE=0.
- In DROPPING, assert DROP_FINISH.
  - STATE=011, COUNTDOWN=2.
  - COUNTDOWN reads 1 then 0 on successive FRAME_TICKs (every 4 cycles).
  - The next tick gives STATE=010 and FREE_MOVE=1.
- Play for 8 FRAME_TICKs with COLLISION=0 and SQUARE_Y=300.
  - SCORE=4; FRAME_TICK period is exactly 4 cycles.
- In PLAYING with SCORE=4, drive SQUARE_Y=496 on a scoring tick cycle.
  - STATE=110, GAME_OVER=1, SCORE stays 4, HIGH_SCORE=4.
- In OVER, press START.
  - SQUARE_RESET is a one-cycle pulse; STATE=000; GAME_OVER=0; FREE_MOVE=0.
  - A second START begins a new drop with SCORE=0 and HIGH_SCORE=4.
- Assert RESET_N low asynchronously mid-COUNTDOWN, between clock edges.
  - All outputs 0 and STATE=000 immediately, before the next CLK edge.
